// File: rtl/opb_register_bank_if.sv
// OPB slave-side bus bundle for opb_register_bank; bit 0 is the MSB on every vector.
interface opb_register_bank_if;
    logic [0:31] ABus;
    logic [0:3]  BE;
    logic [0:31] DBus;
    logic        RNW;
    logic        select;
    logic        seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output ABus, BE, DBus, RNW, select, seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  ABus, BE, DBus, RNW, select, seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank.sv
// OPB register bank: C_NUM_REGS 32-bit registers with byte-enable writes, write strobes,
// self-clearing pulse registers and read-only status registers sourced from the fabric.
module opb_register_bank #(
    parameter logic [31:0]              C_BASEADDR   = 32'h01000A00,
    parameter logic [31:0]              C_HIGHADDR   = 32'h01000AFF,
    parameter int                       C_OPB_AWIDTH = 32,
    parameter int                       C_OPB_DWIDTH = 32,
    parameter                           C_FAMILY     = "virtex5",
    parameter int                       C_NUM_REGS   = 4,
    parameter logic [C_NUM_REGS*32-1:0] C_RESET_VAL  = '0,
    parameter logic [C_NUM_REGS-1:0]    C_PULSE_MASK = '0,
    parameter logic [C_NUM_REGS-1:0]    C_RO_MASK    = '0
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst,
    opb_register_bank_if.slave         opb,
    output logic [C_NUM_REGS*32-1:0]   user_data_out,
    output logic [C_NUM_REGS-1:0]      user_wr_strobe,
    input  logic [C_NUM_REGS*32-1:0]   user_data_in
);
    localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

    typedef enum logic {IDLE, ACK} state_t;

    state_t                         state, state_nxt;
    logic [31:0]                    addr, offset, wdata, be_mask, rd_word, rdata_q;
    logic [29:0]                    word;
    logic                           hit, in_range;
    logic                           rnw_q, valid_q;
    logic [IW-1:0]                  idx_q;
    logic [C_NUM_REGS-1:0][31:0]    regs;
    logic [C_NUM_REGS-1:0]          wr_hit;
    logic                           unused_ok;

    assign addr     = opb.ABus;
    assign wdata    = opb.DBus;
    assign offset   = addr - C_BASEADDR;
    assign word     = offset[31:2];
    assign hit      = opb.select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign in_range = word < 30'(C_NUM_REGS);

    assign unused_ok = ^{opb.seqAddr, offset[1:0], C_FAMILY, C_OPB_AWIDTH[0], C_OPB_DWIDTH[0]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RO registers read the live fabric value; it is captured into rdata_q on the IDLE->ACK edge.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (in_range && word == 30'(i))
                rd_word = C_RO_MASK[i] ? user_data_in[32*i +: 32] : regs[i];
    end

    // BE[0] selects DBus[0:7], which is the most significant byte.
    always_comb begin
        be_mask = '0;
        for (int k = 0; k < 4; k++)
            be_mask[31-8*k -: 8] = {8{opb.BE[k]}};
    end

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            wr_hit[i] = (state == ACK) && !rnw_q && valid_q && (idx_q == IW'(i)) && !C_RO_MASK[i];
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state          <= IDLE;
            rdata_q        <= '0;
            rnw_q          <= 1'b1;
            valid_q        <= 1'b0;
            idx_q          <= '0;
            user_wr_strobe <= '0;
            regs           <= C_RESET_VAL;
        end else begin
            state          <= state_nxt;
            user_wr_strobe <= wr_hit;
            rdata_q        <= '0;
            if (state == IDLE && hit) begin
                rnw_q   <= opb.RNW;
                valid_q <= in_range;
                idx_q   <= word[IW-1:0];
                if (opb.RNW) rdata_q <= rd_word;
            end
            // Pulse registers fall back to their idle value on any edge without a write.
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_hit[i])
                    regs[i] <= (regs[i] & ~be_mask) | (wdata & be_mask);
                else if (C_PULSE_MASK[i])
                    regs[i] <= C_RESET_VAL[32*i +: 32];
            end
        end
    end

    assign user_data_out  = regs;
    assign opb.Sl_DBus    = rdata_q;
    assign opb.Sl_xferAck = (state == ACK);
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;
endmodule

// File: tb/tb_opb_register_bank.sv
// Bench for opb_register_bank: directed vector table, randomized traffic against an
// array-based register model, and hand-written back-to-back and reset-abort sequences.
module tb_opb_register_bank;
    localparam logic [31:0]  BASE  = 32'h01000A00;
    localparam logic [31:0]  HIGH  = 32'h01000AFF;
    localparam logic [127:0] RST   = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    localparam logic [3:0]   PULSE = 4'b0100;
    localparam logic [3:0]   RO    = 4'b1000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] udo;
    logic [3:0]   stb;
    logic [127:0] udi = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl [4];

    opb_register_bank_if bus ();

    opb_register_bank #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
        .C_FAMILY("virtex5"), .C_NUM_REGS(4), .C_RESET_VAL(RST),
        .C_PULSE_MASK(PULSE), .C_RO_MASK(RO)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .opb(bus),
        .user_data_out(udo), .user_wr_strobe(stb), .user_data_in(udi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rnw;
        logic [31:0] data;
        logic [0:3]  be;
        logic [31:0] udi3;
        logic [31:0] exp_rd;
        logic [3:0]  exp_stb;
        logic [31:0] exp_r2;
        logic [31:0] exp_r3;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [0:3] be);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[31-8*k -: 8] = d[31-8*k -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mdl_flat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < 4; i++) mdl[i] = RST[32*i +: 32];
    endfunction

    // Reference behaviour straight from the register-map rules; updates mdl for writes.
    function automatic void predict(input logic [31:0] a, input logic rnw, input logic [31:0] d,
                                    input logic [0:3] be, output logic ack, output logic [31:0] rd,
                                    output logic [3:0] es, output logic [31:0] e2,
                                    output logic [31:0] e3);
        int idx;
        ack = (a >= BASE) && (a <= HIGH);
        idx = ack ? int'((a - BASE) / 4) : 99;
        rd = '0; es = '0;
        e2 = (idx < 4) ? mdl[idx] : '0;
        e3 = e2;
        if (ack && rnw && idx < 4) rd = RO[idx] ? udi[32*idx +: 32] : mdl[idx];
        if (ack && !rnw && idx < 4 && !RO[idx]) begin
            e2 = merge(mdl[idx], d, be);
            es = 4'(1 << idx);
            e3 = PULSE[idx] ? RST[32*idx +: 32] : e2;
            mdl[idx] = e3;
        end
    endfunction

    // Called at a negedge (cycle 0); returns at the negedge of cycle 3.
    task automatic xfer(input logic [31:0] a, input logic rnw, input logic [31:0] d,
                        input logic [0:3] be, input logic ea, input logic [31:0] erd,
                        input logic [3:0] es, input logic [31:0] e2, input logic [31:0] e3,
                        input string nm);
        int idx;
        idx = ((a >= BASE) && (a <= HIGH)) ? int'((a - BASE) / 4) : 99;
        bus.ABus = a; bus.RNW = rnw; bus.DBus = d; bus.BE = be; bus.select = 1'b1;
        @(negedge clk);
        chk({nm, " ack1"}, 128'(bus.Sl_xferAck), 128'(ea));
        chk({nm, " rdata"}, 128'(bus.Sl_DBus), 128'((rnw && ea) ? erd : 32'h0));
        bus.select = 1'b0;
        @(negedge clk);
        chk({nm, " ack2"}, 128'(bus.Sl_xferAck), 128'(0));
        chk({nm, " dbus2"}, 128'(bus.Sl_DBus), 128'(0));
        chk({nm, " strobe"}, 128'(stb), 128'(es));
        if (idx < 4) chk({nm, " reg_c2"}, 128'(udo[32*idx +: 32]), 128'(e2));
        bus.DBus = '0; bus.BE = '0; bus.RNW = 1'b1;
        @(negedge clk);
        chk({nm, " strobe_c3"}, 128'(stb), 128'(0));
        if (idx < 4) chk({nm, " reg_c3"}, 128'(udo[32*idx +: 32]), 128'(e3));
    endtask

    initial begin
        logic        ea;
        logic [31:0] erd, e2, e3, a, d;
        logic [3:0]  es;
        logic [0:3]  be;
        logic        rnw;

        vt[0] = '{32'h01000A04, 1'b0, 32'h12345678, 4'b1111, 32'h0, 32'h0, 4'b0010, 32'h12345678, 32'h12345678};
        vt[1] = '{32'h01000A04, 1'b1, 32'h0,        4'b0000, 32'h0, 32'h12345678, 4'b0000, 32'h12345678, 32'h12345678};
        vt[2] = '{32'h01000A04, 1'b0, 32'hAABBCCDD, 4'b1010, 32'h0, 32'h0, 4'b0010, 32'hAA34CC78, 32'hAA34CC78};
        vt[3] = '{32'h01000A04, 1'b1, 32'h0,        4'b1111, 32'h0, 32'hAA34CC78, 4'b0000, 32'hAA34CC78, 32'hAA34CC78};
        vt[4] = '{32'h01000A08, 1'b0, 32'h00000001, 4'b1111, 32'h0, 32'h0, 4'b0100, 32'h00000001, 32'h0};
        vt[5] = '{32'h01000A08, 1'b1, 32'h0,        4'b0000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0};
        vt[6] = '{32'h01000A0C, 1'b0, 32'hFFFFFFFF, 4'b1111, 32'hCAFE0003, 32'h0, 4'b0000, 32'h0, 32'h0};
        vt[7] = '{32'h01000A0C, 1'b1, 32'h0,        4'b0000, 32'hCAFE0003, 32'hCAFE0003, 4'b0000, 32'h0, 32'h0};
        vt[8] = '{32'h01000A40, 1'b1, 32'h0,        4'b1111, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0};
        vt[9] = '{32'h01000A00, 1'b0, 32'h1234FFFF, 4'b0011, 32'h0, 32'h0, 4'b0001, 32'h0000FFFF, 32'h0000FFFF};

        bus.ABus = '0; bus.BE = '0; bus.DBus = '0; bus.RNW = 1'b1;
        bus.select = 1'b0; bus.seqAddr = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ack", 128'(bus.Sl_xferAck), 128'(0));
        chk("reset dbus", 128'(bus.Sl_DBus), 128'(0));
        chk("reset strobe", 128'(stb), 128'(0));
        chk("reset regs", udo, RST);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            udi = {vt[i].udi3, 96'h0};
            predict(vt[i].addr, vt[i].rnw, vt[i].data, vt[i].be, ea, erd, es, e2, e3);
            xfer(vt[i].addr, vt[i].rnw, vt[i].data, vt[i].be, 1'b1, vt[i].exp_rd,
                 vt[i].exp_stb, vt[i].exp_r2, vt[i].exp_r3, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 60; n++) begin
            udi = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 64)) :
                                                  HIGH + 32'($urandom_range(1, 64));
            else
                a = BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            rnw = 1'($urandom_range(0, 1));
            d   = $urandom();
            be  = 4'($urandom_range(0, 15));
            predict(a, rnw, d, be, ea, erd, es, e2, e3);
            xfer(a, rnw, d, be, ea, erd, es, e2, e3, $sformatf("rnd%0d", n));
            chk($sformatf("rnd%0d all_regs", n), udo, mdl_flat());
        end

        // Select held on one address: acks land on every other cycle.
        bus.ABus = BASE; bus.RNW = 1'b1; bus.select = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("b2b ack c%0d", k), 128'(bus.Sl_xferAck), 128'(k % 2));
            chk($sformatf("b2b dbus c%0d", k), 128'(bus.Sl_DBus),
                128'((k % 2 == 1) ? mdl[0] : 32'h0));
        end
        bus.select = 1'b0;
        @(negedge clk);

        // Reset asserted during the ack cycle aborts the write.
        bus.ABus = BASE + 32'h4; bus.RNW = 1'b0; bus.DBus = 32'h55555555; bus.BE = 4'b1111;
        bus.select = 1'b1;
        @(negedge clk);
        chk("rstack ack1", 128'(bus.Sl_xferAck), 128'(1));
        rst = 1'b1; bus.select = 1'b0;
        @(negedge clk);
        chk("rstack ack2", 128'(bus.Sl_xferAck), 128'(0));
        chk("rstack strobe", 128'(stb), 128'(0));
        chk("rstack regs", udo, RST);
        rst = 1'b0;
        mdl_reset();
        @(negedge clk);
        xfer(BASE + 32'h4, 1'b1, 32'h0, 4'b0000, 1'b1, 32'hDEADBEEF, 4'b0000,
             32'hDEADBEEF, 32'hDEADBEEF, "post_rst_read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
